seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/calc_pkg.sv | 37 +++
 rtl/seg_decode.sv | 28 ++
 rtl/seg_scan.sv | 156 +++++++++++++++
 tb/tb_seg_scan.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the display path.
//   - Seven-segment patterns (bit0=a .. bit6=g, bit7=dp), active-high.
//   - Slot index enumeration for the five display positions.
//   - Packed record holding one full display value (four BCD digits + sign).
package calc_pkg;

  localparam logic [7:0] SEG_D0    = 8'h3F;
  localparam logic [7:0] SEG_D1    = 8'h06;
  localparam logic [7:0] SEG_D2    = 8'h5B;
  localparam logic [7:0] SEG_D3    = 8'h4F;
  localparam logic [7:0] SEG_D4    = 8'h66;
  localparam logic [7:0] SEG_D5    = 8'h6D;
  localparam logic [7:0] SEG_D6    = 8'h7D;
  localparam logic [7:0] SEG_D7    = 8'h07;
  localparam logic [7:0] SEG_D8    = 8'h7F;
  localparam logic [7:0] SEG_D9    = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [2:0] {
    SLOT_ONE  = 3'd0,
    SLOT_TEN  = 3'd1,
    SLOT_HUD  = 3'd2,
    SLOT_THD  = 3'd3,
    SLOT_SIGN = 3'd4
  } slot_e;

  typedef struct packed {
    logic       neg;
    logic [3:0] thd;
    logic [3:0] hud;
    logic [3:0] ten;
    logic [3:0] one;
  } digits_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational BCD to seven-segment conversion.
//   bcd : input  4  BCD digit; codes 10..15 decode to 'E'
//   seg : output 8  segment pattern, bit0=a..bit6=g, bit7=dp (always 0)
module seg_decode
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_E;
    unique case (bcd)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for a 4-digit + sign seven-segment display.
//   Parameters:
//     CLK_DIV : clk cycles per digit slot (2..2^20)
//     DEAD    : blanking cycles at the start of each slot (0..CLK_DIV-1)
//   Ports:
//     clk        : input   rising-edge clock
//     rst_n      : input   synchronous active-low reset
//     load       : input   capture strobe for thd/hud/ten/one/neg
//     thd..one   : input   BCD digits (thousands..ones)
//     neg        : input   negative flag, shown as '-' in the sign slot
//     seg        : output  segment drive (bit7 = dp, held 0), registered
//     sel        : output  one-hot position select [0]=one..[3]=thd,[4]=sign
//     frame_done : output  one-cycle pulse after each frame wrap
//   Build option: define SEG_LZB_EN to blank leading zeros in thd/hud/ten.
module seg_scan
  import calc_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] thd,
  input  logic [3:0] hud,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  input  logic       neg,
  output logic [7:0] seg,
  output logic [4:0] sel,
  output logic       frame_done
);

  localparam int              DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]   DEAD_V   = DW'(DEAD);

  logic [DW-1:0] div_q, div_d;
  slot_e         slot_q, slot_d;
  digits_t       pend_q, pend_d;
  digits_t       disp_q, disp_d;
  logic [7:0]    seg_q, seg_d;
  logic [4:0]    sel_q, sel_d;
  logic          frame_done_q, frame_done_d;

  digits_t       digits_in;
  logic          last_div;
  logic          wrap;
  logic          in_dead;
  logic [3:0]    cur_digit;
  logic [7:0]    dec_seg;
  logic          digit_blank;

  assign digits_in = '{neg: neg, thd: thd, hud: hud, ten: ten, one: one};

  // Avoid an always-false unsigned compare when there is no dead time.
  if (DEAD == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (div_q < DEAD_V);
  end

  seg_decode u_seg_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    div_d        = div_q;
    slot_d       = slot_q;
    pend_d       = pend_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;
    cur_digit    = '0;
    digit_blank  = 1'b0;
    sel_d        = '0;
    seg_d        = SEG_BLANK;

    last_div = (div_q == DIV_LAST);
    wrap     = last_div && (slot_q == SLOT_SIGN);

    if (last_div) begin
      div_d  = '0;
      slot_d = wrap ? SLOT_ONE : slot_e'(slot_q + 3'd1);
    end else begin
      div_d  = div_q + DW'(1);
    end

    if (load) begin
      pend_d = digits_in;
    end

    // A load landing on the wrap cycle would otherwise miss this frame.
    if (wrap) begin
      disp_d = load ? digits_in : pend_q;
    end

    frame_done_d = wrap;

    unique case (slot_q)
      SLOT_ONE: cur_digit = disp_q.one;
      SLOT_TEN: cur_digit = disp_q.ten;
      SLOT_HUD: cur_digit = disp_q.hud;
      SLOT_THD: cur_digit = disp_q.thd;
      default:  cur_digit = '0;
    endcase

`ifdef SEG_LZB_EN
    // A position is a leading zero only if it and every higher digit are 0.
    unique case (slot_q)
      SLOT_THD: digit_blank = (disp_q.thd == 4'd0);
      SLOT_HUD: digit_blank = (disp_q.thd == 4'd0) && (disp_q.hud == 4'd0);
      SLOT_TEN: digit_blank = (disp_q.thd == 4'd0) && (disp_q.hud == 4'd0)
                              && (disp_q.ten == 4'd0);
      default:  digit_blank = 1'b0;
    endcase
`else
    digit_blank = 1'b0;
`endif

    if (!in_dead) begin
      sel_d = 5'b00001 << slot_q;
      if (slot_q == SLOT_SIGN) begin
        seg_d = disp_q.neg ? SEG_DASH : SEG_BLANK;
      end else if (!digit_blank) begin
        seg_d = dec_seg;
      end
    end
    seg_d[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      slot_q       <= SLOT_ONE;
      pend_q       <= '0;
      disp_q       <= '0;
      seg_q        <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed, table-driven bench for seg_scan with CLK_DIV=4, DEAD=1.
// Cycle n counts rising edges since reset release; outputs in cycle n reflect
// scan state n-1, so a frame's outputs occupy cycles 20k+1 .. 20k+20.
module tb_seg_scan;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] thd = '0, hud = '0, ten = '0, one = '0;
  logic       neg = 1'b0;
  logic [7:0] seg;
  logic [4:0] sel;
  logic       frame_done;

  seg_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .thd        (thd),
    .hud        (hud),
    .ten        (ten),
    .one        (one),
    .neg        (neg),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef logic [4:0][7:0] frame_t;   // [0]=one .. [3]=thd, [4]=sign

  typedef struct {
    logic [16:0] ld1;   // {neg, thd, hud, ten, one}
    int          at1;
    logic [16:0] ld2;
    int          at2;   // -1: no second load
    frame_t      exp;
  } vec_t;

  vec_t tbl[7];

  localparam logic [16:0] JUNK = 17'h19999;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [16:0] v, input logic ld);
    {neg, thd, hud, ten, one} = v;
    load = ld;
  endtask

  function automatic frame_t adj(input logic [16:0] v, input frame_t e);
    frame_t r;
    r = e;
`ifdef SEG_LZB_EN
    if (v[15:12] == 4'd0) begin
      r[3] = 8'h00;
      if (v[11:8] == 4'd0) begin
        r[2] = 8'h00;
        if (v[7:4] == 4'd0) r[1] = 8'h00;
      end
    end
`endif
    return r;
  endfunction

  // Check outputs for frame-relative steps j0..j1-1; load ld1/ld2 at their steps.
  task automatic scan(input frame_t exp, input int j0, input int j1,
                      input logic [16:0] ld1, input int at1,
                      input logic [16:0] ld2, input int at2);
    for (int j = j0; j < j1; j++) begin
      if (j % 4 == 0) begin
        check("dead_sel", 32'(sel), 32'h0);
        check("dead_seg", 32'(seg), 32'h0);
      end else begin
        check("sel", 32'(sel), 32'(1) << (j / 4));
        check("seg", 32'(seg), 32'(exp[j / 4]));
      end
      check("frame_done", 32'(frame_done), (j == 19) ? 32'h1 : 32'h0);
      if (j == at1)      drive(ld1, 1'b1);
      else if (j == at2) drive(ld2, 1'b1);
      else               load = 1'b0;
      advance();
    end
    load = 1'b0;
  endtask

  // Reset with junk loads presented; ends at cycle 1 after release.
  task automatic reset_seq(input string tag);
    rst_n = 1'b0;
    drive(JUNK, 1'b1);
    advance();
    check({tag, "_sel"}, 32'(sel), 32'h0);
    check({tag, "_seg"}, 32'(seg), 32'h0);
    check({tag, "_fd"},  32'(frame_done), 32'h0);
    advance();
    rst_n = 1'b1;
    drive(17'h0, 1'b0);
    cyc = 0;
    check({tag, "_rel_seg"}, 32'(seg), 32'h0);
    check({tag, "_rel_sel"}, 32'(sel), 32'h0);
    advance();
  endtask

  frame_t zeros;
  frame_t prev;

  initial begin
    zeros = adj(17'h0, {8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F});

    tbl[0] = '{17'h11234, 7,  17'h0, -1, {8'h40, 8'h06, 8'h5B, 8'h4F, 8'h66}};
    tbl[1] = '{17'h00009, 18, 17'h0, -1, {8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h6F}};
    tbl[2] = '{17'h0000C, 7,  17'h0, -1, {8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h79}};
    tbl[3] = '{17'h08765, 7,  17'h0, -1, {8'h00, 8'h7F, 8'h07, 8'h7D, 8'h6D}};
    tbl[4] = '{17'h1FA00, 10, 17'h0, -1, {8'h40, 8'h79, 8'h79, 8'h3F, 8'h3F}};
    tbl[5] = '{17'h00020, 7,  17'h0, -1, {8'h00, 8'h3F, 8'h3F, 8'h5B, 8'h3F}};
    tbl[6] = '{17'h00005, 3,  17'h00007, 11, {8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h07}};

    repeat (3) @(negedge clk);
    reset_seq("rst_init");

    // Two idle frames: reset display, and no leak of loads made during reset.
    scan(zeros, 0, 20, 17'h0, -1, 17'h0, -1);
    scan(zeros, 0, 20, 17'h0, -1, 17'h0, -1);

    // Each frame shows the previous record while the current one is loaded.
    prev = zeros;
    for (int i = 0; i < 7; i++) begin
      scan(prev, 0, 20, tbl[i].ld1, tbl[i].at1, tbl[i].ld2, tbl[i].at2);
      prev = adj((tbl[i].at2 >= 0) ? tbl[i].ld2 : tbl[i].ld1, tbl[i].exp);
    end

    // Mid-frame reset in slot 2 with a pending load that must be discarded.
    scan(prev, 0, 9, JUNK, 2, 17'h0, -1);
    reset_seq("rst_mid");
    scan(zeros, 0, 20, 17'h0, -1, 17'h0, -1);
    scan(zeros, 0, 20, 17'h0, -1, 17'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
